ram_eraser: RTL and testbench

- Per-bank RAM fill engine, one instance per DDR bank.
- Sits directly downstream of the system-control block: consumes its erase-request strobe and returns the erase-idle status that gates packet flow.
- On request, writes FILL_PATTERN over the whole bank [RAM_BASE, RAM_BASE+RAM_SIZE) using AXI4 INCR write bursts, then reports idle.
- Write-only AXI4 master; runs in the bank's AXI clock domain.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/ram_eraser.sv | 209 ++++++++++++++++++++
 tb/tb_ram_eraser.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// AXI4 encodings shared by the bank-side masters.
// Holds burst/response codes, the AxSIZE helper and the eraser state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RUN
  } erase_state_e;

  // AxSIZE encoding for a beat of the given byte count (power of two)
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/ram_eraser.sv
// Per-bank RAM fill engine: writes FILL_PATTERN over the bank with
// AXI4 INCR bursts, keeping AW, W and B channels independent.
module ram_eraser
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter logic [63:0] RAM_BASE        = 64'h0,
  parameter logic [63:0] RAM_SIZE        = 64'h2_0000_0000,
  parameter int unsigned BURST_LEN       = 64,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter logic [31:0] FILL_PATTERN    = 32'hFFFF_FFFF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    erase_req,
  output logic                    erase_idle,
  output logic                    erase_error,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY
);

  localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;

  localparam logic [31:0] NUM_BURSTS =
    32'(RAM_SIZE / 64'(BURST_BYTES));
  localparam logic [31:0] MAX_OUT = 32'(MAX_OUTSTANDING);
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE =
    ADDR_WIDTH'(RAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP =
    ADDR_WIDTH'(BURST_BYTES);
  localparam logic [2:0] AW_SIZE = axi_size(BEAT_BYTES);

  erase_state_e state_q, state_d;

  logic idle_q, idle_d;
  logic error_q, error_d;

  logic                  awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           aw_count_q, aw_count_d;

  logic        wvalid_q, wvalid_d;
  logic        wlast_q, wlast_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] w_count_q, w_count_d;

  logic [31:0] b_count_q, b_count_d;

  logic start;
  logic run;
  logic stay;
  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign start = (state_q == ST_IDLE) && erase_req;
  assign run   = (state_q == ST_RUN);
  assign stay  = (state_d == ST_RUN);
  assign aw_hs = awvalid_q && M_AXI_AWREADY;
  assign w_hs  = wvalid_q && M_AXI_WREADY;
  assign b_hs  = run && M_AXI_BVALID;

  // Control FSM and B counter; erase ends once every burst has a response
  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    error_d   = error_q;
    b_count_d = b_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (erase_req) begin
          state_d   = ST_RUN;
          idle_d    = 1'b0;
          error_d   = 1'b0;
          b_count_d = '0;
        end
      end
      ST_RUN: begin
        if (b_hs) begin
          b_count_d = b_count_q + 32'd1;
          if (M_AXI_BRESP != AXI_RESP_OKAY) error_d = 1'b1;
        end
        if (b_count_d == NUM_BURSTS) begin
          state_d = ST_IDLE;
          idle_d  = 1'b1;
        end
      end
    endcase
  end

  // AW issuer: hold until accepted, then throttle on outstanding count
  always_comb begin
    awvalid_d  = 1'b0;
    awaddr_d   = awaddr_q;
    aw_count_d = aw_count_q;
    unique case (1'b1)
      start: begin
        awaddr_d   = ADDR_BASE;
        aw_count_d = '0;
        awvalid_d  = 1'b1;
      end
      run: begin
        if (aw_hs) begin
          aw_count_d = aw_count_q + 32'd1;
          awaddr_d   = awaddr_q + ADDR_STEP;
        end
        if (awvalid_q && !M_AXI_AWREADY) begin
          awvalid_d = 1'b1;
        end else begin
          awvalid_d = (aw_count_d < NUM_BURSTS) &&
                      ((aw_count_d - b_count_d) < MAX_OUT);
        end
      end
      default: ;
    endcase
    awvalid_d = awvalid_d && stay;
  end

  // W issuer: only bursts whose AW is accepted, back-to-back when possible
  always_comb begin
    wvalid_d  = 1'b0;
    wlast_d   = 1'b0;
    beat_d    = beat_q;
    w_count_d = w_count_q;
    unique case (1'b1)
      start: begin
        beat_d    = '0;
        w_count_d = '0;
      end
      run: begin
        if (w_hs) begin
          if (wlast_q) begin
            beat_d    = '0;
            w_count_d = w_count_q + 32'd1;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
        if (wvalid_q && !M_AXI_WREADY) begin
          wvalid_d = 1'b1;
        end else begin
          wvalid_d = (w_count_d < aw_count_d);
        end
      end
      default: ;
    endcase
    wvalid_d = wvalid_d && stay;
    wlast_d  = wvalid_d && (beat_d == LAST_BEAT);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      idle_q     <= 1'b1;
      error_q    <= 1'b0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= ADDR_BASE;
      aw_count_q <= '0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      beat_q     <= '0;
      w_count_q  <= '0;
      b_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      error_q    <= error_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      aw_count_q <= aw_count_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      beat_q     <= beat_d;
      w_count_q  <= w_count_d;
      b_count_q  <= b_count_d;
    end
  end

  assign erase_idle    = idle_q;
  assign erase_error   = error_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = AW_SIZE;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = {(DATA_WIDTH/32){FILL_PATTERN}};
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = 1'b1;

endmodule

// File: tb/tb_ram_eraser.sv
// Bench for ram_eraser: AXI slave model, scenario table and
// directed corner sequences (re-request, reset, single-beat bursts).
module tb_ram_eraser;

  localparam int NB = 64;
  localparam int BL = 4;
  localparam int BB = 256;
  localparam int NBEAT = 256;
  localparam logic [511:0] FILL = {16{32'hFFFF_FFFF}};

  typedef struct {
    bit rnd;
    bit bhold;
    int err_idx;
    bit exp_err;
    bit max16;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic erase_req = 1'b0;
  logic erase_idle, erase_error;
  logic [63:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid;
  logic awready = 1'b0;
  logic [511:0] wdata;
  logic [63:0] wstrb;
  logic wlast, wvalid;
  logic wready = 1'b0;
  logic [1:0] bresp = 2'b00;
  logic bvalid = 1'b0;
  logic bready;

  logic erase_req1 = 1'b0;
  logic erase_idle1, erase_error1;
  logic [63:0] awaddr1;
  logic [7:0] awlen1;
  logic [2:0] awsize1;
  logic [1:0] awburst1;
  logic awvalid1;
  logic awready1 = 1'b1;
  logic [511:0] wdata1;
  logic [63:0] wstrb1;
  logic wlast1, wvalid1;
  logic wready1 = 1'b1;
  logic [1:0] bresp1 = 2'b00;
  logic bvalid1 = 1'b0;
  logic bready1;

  always #5 clk = ~clk;

  ram_eraser #(
    .DATA_WIDTH(512), .ADDR_WIDTH(64), .RAM_BASE(64'h0),
    .RAM_SIZE(64'd16384), .BURST_LEN(4), .MAX_OUTSTANDING(16),
    .FILL_PATTERN(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .resetn(resetn), .erase_req(erase_req),
    .erase_idle(erase_idle), .erase_error(erase_error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  ram_eraser #(
    .DATA_WIDTH(512), .ADDR_WIDTH(64), .RAM_BASE(64'h0),
    .RAM_SIZE(64'd256), .BURST_LEN(1), .MAX_OUTSTANDING(16),
    .FILL_PATTERN(32'hFFFF_FFFF)
  ) dut1 (
    .clk(clk), .resetn(resetn), .erase_req(erase_req1),
    .erase_idle(erase_idle1), .erase_error(erase_error1),
    .M_AXI_AWADDR(awaddr1), .M_AXI_AWLEN(awlen1),
    .M_AXI_AWSIZE(awsize1), .M_AXI_AWBURST(awburst1),
    .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(awready1),
    .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1),
    .M_AXI_WLAST(wlast1), .M_AXI_WVALID(wvalid1),
    .M_AXI_WREADY(wready1), .M_AXI_BRESP(bresp1),
    .M_AXI_BVALID(bvalid1), .M_AXI_BREADY(bready1)
  );

  int total = 0;
  int bad = 0;

  bit rnd = 1'b0;
  bit bhold = 1'b0;
  int err_idx = -1;

  int cyc = 0;
  int aw_n, w_done, w_beats, wbeat, b_n;
  int aw_bad, w_bad, w_lead, max_o, last_b_cyc;
  int mem_wr[NBEAT];
  logic [63:0] awa[NB];
  int widx;

  int awn1 = 0, wn1 = 0, bn1 = 0, aw1bad = 0, w1bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function void mon_clear();
    aw_n = 0; w_done = 0; w_beats = 0; wbeat = 0; b_n = 0;
    aw_bad = 0; w_bad = 0; w_lead = 0; max_o = 0;
    last_b_cyc = -100;
    for (int k = 0; k < NBEAT; k++) mem_wr[k] = 0;
  endfunction

  // Slave model for the main instance, acting just after each negedge
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!resetn) begin
      awready = 1'b0;
      wready = 1'b0;
      bvalid = 1'b0;
      bresp = 2'b00;
      mon_clear();
    end else begin
      if (bhold)
        bvalid = (w_done > b_n) && ($urandom_range(0, 19) == 0);
      else if (rnd)
        bvalid = (w_done > b_n) && ($urandom_range(0, 2) == 0);
      else
        bvalid = (w_done > b_n);
      bresp = (bvalid && b_n == err_idx) ? 2'b10 : 2'b00;
      if (bvalid) begin
        b_n++;
        last_b_cyc = cyc;
      end
      wready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (wvalid && wready) begin
        if (w_done >= aw_n) w_lead++;
        if (wdata !== FILL || wstrb !== '1 ||
            wlast !== (wbeat == BL - 1)) w_bad++;
        if (w_done < aw_n && w_done < NB) begin
          widx = int'((awa[w_done] + 64'(wbeat * 64)) / 64);
          if (widx < NBEAT) mem_wr[widx]++;
        end
        w_beats++;
        if (wbeat == BL - 1) begin
          wbeat = 0;
          w_done++;
        end else begin
          wbeat++;
        end
      end
      awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (awvalid && awready) begin
        if (aw_n >= NB || awaddr !== 64'(aw_n * BB) ||
            awlen !== 8'd3 || awsize !== 3'd6 ||
            awburst !== 2'b01) aw_bad++;
        if (aw_n < NB) awa[aw_n] = awaddr;
        aw_n++;
      end
      if (aw_n - b_n > max_o) max_o = aw_n - b_n;
    end
  end

  // Always-ready slave for the single-beat instance
  always @(negedge clk) begin
    #1;
    if (!resetn) begin
      bvalid1 = 1'b0;
      awn1 = 0; wn1 = 0; bn1 = 0; aw1bad = 0; w1bad = 0;
    end else begin
      bvalid1 = (wn1 > bn1);
      if (bvalid1) bn1++;
      if (wvalid1) begin
        if (wlast1 !== 1'b1 || wn1 >= awn1 ||
            wdata1 !== FILL) w1bad++;
        wn1++;
      end
      if (awvalid1) begin
        if (awaddr1 !== 64'(awn1 * 64) || awlen1 !== 8'd0)
          aw1bad++;
        awn1++;
      end
    end
  end

  task automatic start_erase();
    @(negedge clk);
    mon_clear();
    chk("pre_idle", 64'(erase_idle), 64'd1);
    erase_req = 1'b1;
    @(negedge clk);
    erase_req = 1'b0;
    chk("start_idle", 64'(erase_idle), 64'd0);
    chk("start_awvalid", 64'(awvalid), 64'd1);
    chk("start_awaddr", awaddr, 64'd0);
    chk("start_error", 64'(erase_error), 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (erase_idle !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_budget", 64'(n < 20000), 64'd1);
    chk("idle_latency", 64'(cyc), 64'(last_b_cyc));
  endtask

  task automatic check_run(input bit exp_err, input bit max16);
    int once = 0;
    for (int k = 0; k < NBEAT; k++)
      if (mem_wr[k] == 1) once++;
    chk("aw_count", 64'(aw_n), 64'(NB));
    chk("w_bursts", 64'(w_done), 64'(NB));
    chk("w_beats", 64'(w_beats), 64'(NBEAT));
    chk("b_count", 64'(b_n), 64'(NB));
    chk("aw_fields", 64'(aw_bad), 64'd0);
    chk("w_fields", 64'(w_bad), 64'd0);
    chk("w_lead_aw", 64'(w_lead), 64'd0);
    chk("max_out_le16", 64'(max_o <= 16), 64'd1);
    if (max16) chk("max_out_16", 64'(max_o), 64'd16);
    chk("mem_filled_once", 64'(once), 64'(NBEAT));
    chk("erase_error", 64'(erase_error), 64'(exp_err));
    chk("end_awvalid", 64'(awvalid), 64'd0);
    chk("end_wvalid", 64'(wvalid), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int n;
    vecs[0] = '{0, 0, -1, 0, 0};
    vecs[1] = '{1, 0, -1, 0, 0};
    vecs[2] = '{1, 1, -1, 0, 1};
    vecs[3] = '{0, 0, 10, 1, 0};
    vecs[4] = '{0, 0, -1, 0, 0};
    vecs[5] = '{1, 1, 10, 1, 1};

    mon_clear();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", 64'(erase_idle), 64'd1);
    chk("rst_error", 64'(erase_error), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_awaddr", awaddr, 64'd0);
    chk("awlen", 64'(awlen), 64'd3);
    chk("awsize", 64'(awsize), 64'd6);
    chk("awburst", 64'(awburst), 64'd1);
    chk("bready", 64'(bready), 64'd1);
    chk("wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_idle1", 64'(erase_idle1), 64'd1);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      rnd = vecs[i].rnd;
      bhold = vecs[i].bhold;
      err_idx = vecs[i].err_idx;
      start_erase();
      wait_idle();
      check_run(vecs[i].exp_err, vecs[i].max16);
    end

    rnd = 1'b0;
    bhold = 1'b0;
    err_idx = -1;

    start_erase();
    n = 0;
    while (aw_n < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    erase_req = 1'b1;
    @(negedge clk);
    erase_req = 1'b0;
    chk("rereq_busy", 64'(erase_idle), 64'd0);
    wait_idle();
    check_run(1'b0, 1'b0);

    start_erase();
    n = 0;
    while (!(b_n == NB - 1 && w_done == NB) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("final_b_reached", 64'(n < 5000), 64'd1);
    erase_req = 1'b1;
    @(negedge clk);
    erase_req = 1'b0;
    chk("req_at_done_idle", 64'(erase_idle), 64'd1);
    chk("req_at_done_awvalid", 64'(awvalid), 64'd0);
    @(negedge clk);
    chk("req_at_done_stay_idle", 64'(erase_idle), 64'd1);
    chk("req_at_done_awvalid2", 64'(awvalid), 64'd0);
    chk("req_at_done_b", 64'(b_n), 64'(NB));

    start_erase();
    n = 0;
    while (b_n < 20 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_20_bursts", 64'(n < 5000), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_rst_idle", 64'(erase_idle), 64'd1);
    chk("mid_rst_awvalid", 64'(awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(wvalid), 64'd0);
    chk("mid_rst_wlast", 64'(wlast), 64'd0);
    chk("mid_rst_awaddr", awaddr, 64'd0);
    chk("mid_rst_error", 64'(erase_error), 64'd0);
    start_erase();
    wait_idle();
    check_run(1'b0, 1'b0);

    @(negedge clk);
    erase_req1 = 1'b1;
    @(negedge clk);
    erase_req1 = 1'b0;
    chk("c_start_idle", 64'(erase_idle1), 64'd0);
    chk("c_awlen", 64'(awlen1), 64'd0);
    chk("c_awvalid", 64'(awvalid1), 64'd1);
    n = 0;
    while (erase_idle1 !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("c_done_in_budget", 64'(n < 1000), 64'd1);
    chk("c_aw_count", 64'(awn1), 64'd4);
    chk("c_w_count", 64'(wn1), 64'd4);
    chk("c_b_count", 64'(bn1), 64'd4);
    chk("c_aw_fields", 64'(aw1bad), 64'd0);
    chk("c_w_fields", 64'(w1bad), 64'd0);
    chk("c_error", 64'(erase_error1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
